hov_chan_fifo: RTL
==================

HOV_CHAN_FIFO -- requirements
Module: hov_chan_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 12: data word width (matches the 12-bit core I/O word).
REQ-002 SHALL have parameter DEPTH, default 8: entries per channel; power of two, >= 2.
REQ-003 SHALL have parameter CHANNELS, default 2: independent FIFO channels, >= 1.
REQ-004 SHALL define CW = max(1, clog2(CHANNELS)) and LW = clog2(DEPTH+1).
REQ-005 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port ena  input  1  global enable; low freezes all state.
REQ-008 SHALL have port clr  input  1  synchronous clear of all channels.
REQ-009 SHALL have port wr_valid  input  1  write request.
REQ-010 SHALL have port wr_ch  input  CW  write channel select.
REQ-011 SHALL have port wr_data  input  WIDTH  write word.
REQ-012 SHALL have port wr_ready  output  1  write acceptable this cycle (combinational).
REQ-013 SHALL have port rd_req  input  1  read request.
REQ-014 SHALL have port rd_ch  input  CW  read channel select.
REQ-015 SHALL have port rd_valid  output  1  registered; rd_data valid this cycle.
REQ-016 SHALL have port rd_data  output  WIDTH  registered read word.
REQ-017 SHALL have port full  output  CHANNELS  per-channel full flag.
REQ-018 SHALL have port empty  output  CHANNELS  per-channel empty flag.
REQ-019 SHALL have port overflow  output  CHANNELS  sticky: write attempted while full.
REQ-020 SHALL have port underflow  output  CHANNELS  sticky: read attempted while empty.
REQ-021 SHALL have port level  output  CHANNELS*LW  per-channel occupancy, channel 0 in LSBs.

Function
REQ-022 wr_ready SHALL equal ena && !clr && wr_ch < CHANNELS && !full[wr_ch].
REQ-023 Write SHALL be accepted when wr_valid && wr_ready; word stored at channel write pointer, pointer += 1 mod DEPTH.
REQ-024 wr_valid with full[wr_ch], ena high, clr low SHALL set overflow[wr_ch] and drop the word.
REQ-025 wr_ch >= CHANNELS SHALL be ignored: no store, no flag change.
REQ-026 Read SHALL be accepted when rd_req && ena && !clr && rd_ch < CHANNELS && !empty[rd_ch]; next cycle rd_valid=1, rd_data = head word; read pointer += 1 mod DEPTH.
REQ-027 Read latency SHALL be exactly 1 cycle; back-to-back reads SHALL yield one word per cycle.
REQ-028 Cycle without accepted read SHALL give rd_valid=0 next cycle; rd_data SHALL hold last value.
REQ-029 rd_req on empty channel (ena high, clr low) SHALL set underflow[rd_ch].
REQ-030 No fall-through: write and read of the same empty channel in one cycle SHALL accept the write, refuse the read, set underflow.
REQ-031 Same non-empty, non-full channel written and read in one cycle: both accepted, level unchanged.
REQ-032 Full channel written and read in one cycle: read accepted, write refused, overflow set.
REQ-033 Operations on different channels in one cycle SHALL be fully independent.
REQ-034 full/empty/level SHALL be registered-state-derived: full = (level==DEPTH), empty = (level==0).
REQ-035 clr SHALL zero pointers, levels, overflow, underflow, rd_valid next cycle, overriding simultaneous wr/rd; rd_data holds.
REQ-036 ena low SHALL freeze all state except rd_valid, which SHALL be 0 next cycle.

Reset
REQ-037 rst_n low SHALL immediately force: pointers=0, level=0, empty=all 1, full=0, overflow=0, underflow=0, rd_valid=0, rd_data=0.
REQ-038 Storage array SHALL NOT be reset; contents undefined until written.
REQ-039 Reset mid-operation SHALL discard all queued words; first read after release returns first word written after release.

Structure
REQ-040 Package hov_fifo_pkg SHALL hold default WIDTH/DEPTH/CHANNELS constants and CW/LW width functions.
REQ-041 Sub-module hov_fifo_chan (one channel: storage, pointers, level, flags) SHALL be instantiated CHANNELS times; top holds select decode, rd_data mux/register.

Verification
REQ-042 Reset, write 0xABC,0x123 to ch0, read ch0 twice -> rd_valid 1 cycle after each, rd_data 0xABC then 0x123, empty[0]=1 after.
REQ-043 Write 8 words to ch1 (DEPTH=8) -> full[1]=1, level[1]=8, wr_ready=0 for ch1; 9th write -> overflow[1]=1, ch0 unaffected.
REQ-044 Fill/drain ch0 20 times with counting data -> pointer wrap, data order 0..N exact, no flags set.
REQ-045 Simultaneous write ch0 and read ch0 while empty -> level[0]=1, rd_valid=0, underflow[0]=1; repeat at level 3 -> level stays 3.
REQ-046 Queue 3 words, pulse clr with wr_valid high -> level=0, flags clear, word not stored; ena low 4 cycles -> no level change, rd_valid=0.
REQ-047 Assert rst_n low asynchronously mid-burst -> outputs at reset values before next clk edge.

Source files
------------

// File: rtl/hov_fifo_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : hov_fifo_pkg                                          |
// | Purpose  : Shared defaults and width helpers for the multi-      |
// |            channel FIFO (hov_chan_fifo / hov_fifo_chan).         |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
package hov_fifo_pkg;

  // Defaults sized for the 12-bit core I/O word.
  localparam int DEF_WIDTH    = 12;
  localparam int DEF_DEPTH    = 8;
  localparam int DEF_CHANNELS = 2;

  // Channel-select width; a single channel still needs a 1-bit select.
  function automatic int calc_cw(input int channels);
    int w;
    w = $clog2(channels);
    return (w < 1) ? 1 : w;
  endfunction

  // Occupancy width; must be able to represent DEPTH itself (full).
  function automatic int calc_lw(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage : hov_fifo_pkg
`default_nettype wire

// File: rtl/hov_fifo_chan.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : hov_fifo_chan                                         |
// | Purpose  : One FIFO channel: storage, read/write pointers,       |
// |            occupancy counter and sticky overflow/underflow.      |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module hov_fifo_chan
  import hov_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int LW   = calc_lw(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,      // already qualified with the global enable
  input  logic             wr_sel_i,   // write request aimed at this channel
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_sel_i,   // read request aimed at this channel
  output logic [WIDTH-1:0] head_o,     // word at the read pointer
  output logic             rd_acc_o,   // read accepted this cycle
  output logic             full_o,
  output logic             empty_o,
  output logic             overflow_o,
  output logic             underflow_o,
  output logic [LW-1:0]    level_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q,  level_d;
  logic             ovf_q,    ovf_d;
  logic             unf_q,    unf_d;

  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_rd_acc;

  // Flags come straight from the registered occupancy. A read is judged
  // against the occupancy before this cycle's write, so there is no
  // fall-through, and a write to a full channel is refused even if a read
  // frees a slot in the same cycle.
  assign w_full   = (level_q == LW'(DEPTH));
  assign w_empty  = (level_q == '0);
  assign w_wr_acc = wr_sel_i & ~w_full;
  assign w_rd_acc = rd_sel_i & ~w_empty;

  assign head_o      = mem_q[rd_ptr_q];
  assign rd_acc_o    = w_rd_acc;
  assign full_o      = w_full;
  assign empty_o     = w_empty;
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;
  assign level_o     = level_q;

  // Next-state for pointers, occupancy and sticky error flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (w_wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
      if (w_rd_acc) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({w_wr_acc, w_rd_acc})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
      if (wr_sel_i && w_full)  ovf_d = 1'b1;
      if (rd_sel_i && w_empty) unf_d = 1'b1;
    end
  end

  // Control state register; reset drops every queued word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is deliberately unreset so it can map onto plain RAM/regfile.
  always_ff @(posedge clk) begin
    if (w_wr_acc) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule : hov_fifo_chan
`default_nettype wire

// File: rtl/hov_chan_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : hov_chan_fifo                                         |
// | Purpose  : CHANNELS independent FIFOs sharing one write port and |
// |            one registered read port (1-cycle read latency).      |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module hov_chan_fifo
  import hov_fifo_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int CHANNELS = DEF_CHANNELS,
  localparam int CW      = calc_cw(CHANNELS),
  localparam int LW      = calc_lw(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic                   clr,
  input  logic                   wr_valid,
  input  logic [CW-1:0]          wr_ch,
  input  logic [WIDTH-1:0]       wr_data,
  output logic                   wr_ready,
  input  logic                   rd_req,
  input  logic [CW-1:0]          rd_ch,
  output logic                   rd_valid,
  output logic [WIDTH-1:0]       rd_data,
  output logic [CHANNELS-1:0]    full,
  output logic [CHANNELS-1:0]    empty,
  output logic [CHANNELS-1:0]    overflow,
  output logic [CHANNELS-1:0]    underflow,
  output logic [CHANNELS*LW-1:0] level
);

  logic                w_active;   // enabled and not clearing
  logic                w_clr;      // clear only acts while enabled
  logic [CHANNELS-1:0] w_wr_sel;
  logic [CHANNELS-1:0] w_rd_sel;
  logic [CHANNELS-1:0] w_rd_acc;
  logic                w_wr_hit;   // wr_ch names an existing channel
  logic                w_wr_full;  // that channel is full
  logic [WIDTH-1:0]    w_head [CHANNELS];
  logic [WIDTH-1:0]    w_rd_word;
  logic                w_rd_any;

  logic                rd_valid_q;
  logic [WIDTH-1:0]    rd_data_q;

  assign w_active = ena & ~clr;
  assign w_clr    = ena & clr;

  // Channel-select decode; selects beyond CHANNELS match nothing and are ignored.
  always_comb begin
    w_wr_sel  = '0;
    w_rd_sel  = '0;
    w_wr_hit  = 1'b0;
    w_wr_full = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (wr_ch == CW'(i)) begin
        w_wr_hit    = 1'b1;
        w_wr_full   = full[i];
        w_wr_sel[i] = w_active & wr_valid;
      end
      if (rd_ch == CW'(i)) begin
        w_rd_sel[i] = w_active & rd_req;
      end
    end
  end

  assign wr_ready = w_active & w_wr_hit & ~w_wr_full;

  generate
    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
      hov_fifo_chan #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
      ) u_chan (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (w_clr),
        .wr_sel_i    (w_wr_sel[g]),
        .wr_data_i   (wr_data),
        .rd_sel_i    (w_rd_sel[g]),
        .head_o      (w_head[g]),
        .rd_acc_o    (w_rd_acc[g]),
        .full_o      (full[g]),
        .empty_o     (empty[g]),
        .overflow_o  (overflow[g]),
        .underflow_o (underflow[g]),
        .level_o     (level[g*LW +: LW])
      );
    end
  endgenerate

  // Read-data mux: at most one channel accepts a read per cycle.
  always_comb begin
    w_rd_word = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_rd_acc[i]) w_rd_word = w_head[i];
    end
  end

  assign w_rd_any = |w_rd_acc;

  // Registered read port; rd_data holds its last word when no read lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= w_rd_any;
      if (w_rd_any) rd_data_q <= w_rd_word;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule : hov_chan_fifo
`default_nettype wire
